// File: rtl/cmp_threshold_monitor.sv
// Debounced, hysteretic alarm driven by a magnitude comparator's one-hot result.
// Also keeps a saturating count of accepted "greater" samples and flags malformed compare vectors.
module cmp_threshold_monitor #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned SET_CNT = 4,
  parameter int unsigned CLR_CNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             smaller,
  input  logic             equal,
  input  logic             greater,
  output logic             alarm,
  output logic             alarm_rise,
  output logic             alarm_fall,
  output logic [CNT_W-1:0] gt_count,
  output logic             err_onehot
);

  localparam logic [CNT_W-1:0] SET_V = CNT_W'(SET_CNT);
  localparam logic [CNT_W-1:0] CLR_V = CNT_W'(CLR_CNT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMING   = 2'd1,
    ALARM    = 2'd2,
    CLEARING = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] run, run_d, run_inc;
  logic [CNT_W-1:0] gt_count_d;
  logic             rise_d, fall_d, err_d;
  logic             onehot, accepted;

  assign onehot   = ({smaller, equal, greater} == 3'b100) ||
                    ({smaller, equal, greater} == 3'b010) ||
                    ({smaller, equal, greater} == 3'b001);
  assign accepted = valid_in & onehot;
  assign run_inc  = run + CNT_W'(1);

  // Next-state, run counter, saturating count and pulse generation.
  always_comb begin
    state_d    = state;
    run_d      = run;
    gt_count_d = gt_count;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    err_d      = valid_in & ~onehot;
    if (accepted) begin
      if (greater && (gt_count != '1)) gt_count_d = gt_count + CNT_W'(1);
      case (state)
        IDLE: begin
          if (greater) begin
            state_d = ARMING;
            run_d   = CNT_W'(1);
          end else begin
            run_d   = '0;
          end
        end
        ARMING: begin
          if (greater) begin
            if (run_inc == SET_V) begin
              state_d = ALARM;
              run_d   = '0;
              rise_d  = 1'b1;
            end else begin
              run_d   = run_inc;
            end
          end else begin
            state_d = IDLE;
            run_d   = '0;
          end
        end
        ALARM: begin
          if (smaller) begin
            state_d = CLEARING;
            run_d   = CNT_W'(1);
          end else begin
            run_d   = '0;
          end
        end
        CLEARING: begin
          if (smaller) begin
            if (run_inc == CLR_V) begin
              state_d = IDLE;
              run_d   = '0;
              fall_d  = 1'b1;
            end else begin
              run_d   = run_inc;
            end
          end else if (greater) begin
            state_d = ALARM;
            run_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      run        <= '0;
      gt_count   <= '0;
      alarm      <= 1'b0;
      alarm_rise <= 1'b0;
      alarm_fall <= 1'b0;
      err_onehot <= 1'b0;
    end else begin
      state      <= state_d;
      run        <= run_d;
      gt_count   <= gt_count_d;
      alarm      <= (state_d == ALARM) || (state_d == CLEARING);
      alarm_rise <= rise_d;
      alarm_fall <= fall_d;
      err_onehot <= err_d;
    end
  end

endmodule
